// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the Xillybus SPI command path.
//   - cmd_state_t : unpacker FSM state (IDLE / LOW / HIGH)
//   - CMD_W, HOST_W : command word and host word widths
//   - LO_LSB, HI_LSB : bit offsets of the two command halves in a host word
//   - lo_half / hi_half : helpers that extract the two command halves
package spi_cmd_pkg;

  localparam int CMD_W  = 16;
  localparam int HOST_W = 32;

  // Bits [15:0] go out first, bits [31:16] second.
  localparam int LO_LSB = 0;
  localparam int HI_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } cmd_state_t;

  function automatic logic [CMD_W-1:0] lo_half(input logic [HOST_W-1:0] w);
    return w[LO_LSB +: CMD_W];
  endfunction

  function automatic logic [CMD_W-1:0] hi_half(input logic [HOST_W-1:0] w);
    return w[HI_LSB +: CMD_W];
  endfunction

endpackage

// File: rtl/spi_cmd_sync_fifo.sv
// spi_cmd_sync_fifo: single-clock FIFO with combinational read port.
//   clk          : clock
//   flush        : synchronous clear of pointers and count (covers reset)
//   push / wdata : write request and data; ignored while full
//   pop  / rdata : read request; rdata always shows the head entry
//   count        : entries held, 0..DEPTH
//   full / empty : derived from count
module spi_cmd_sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == LVL_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Full/empty come from the pre-edge count, so a pop in the same cycle
  // never makes room for a push into a full buffer.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is not cleared; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_xillybus_cmd_interface.sv
// spi_xillybus_cmd_interface: takes 32-bit host words from a Xillybus write
// pipe, buffers them, and streams them out as two 16-bit SPI commands each
// (bits [15:0] first, then bits [31:16]).
//   bus_clk, reset_n            : clock, synchronous active-low reset
//   user_w_spi_cmd_32_open      : pipe open; low flushes everything
//   user_w_spi_cmd_32_wren/data : host write strobe and word
//   user_w_spi_cmd_32_full      : FIFO holds DEPTH words
//   cmd_data / cmd_valid        : registered command stream
//   cmd_ready                   : consumer accept; transfer on valid & ready
//   cmd_level                   : words in the FIFO (not counting the unpacker)
//   cmd_overflow                : sticky, set by a write while full
//   cmd_count                   : completed 16-bit handshakes, only when
//                                 SPI_CMD_WORD_CNT_EN is defined
// Stream handshake: cmd_data/cmd_valid change only after a cycle with
// cmd_valid & cmd_ready (or on flush); a valid word is never retracted.
module spi_xillybus_cmd_interface
  import spi_cmd_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  input  logic              user_w_spi_cmd_32_open,
  input  logic              user_w_spi_cmd_32_wren,
  input  logic [HOST_W-1:0] user_w_spi_cmd_32_data,
  output logic              user_w_spi_cmd_32_full,
  output logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [LVL_W-1:0]  cmd_level,
  output logic              cmd_overflow
`ifdef SPI_CMD_WORD_CNT_EN
  ,
  output logic [31:0]       cmd_count
`endif
);

  logic              flush;
  logic              fifo_push, fifo_pop;
  logic [HOST_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              handshake;

  cmd_state_t        state_q, state_d;
  logic [CMD_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [CMD_W-1:0]  hi_q, hi_d;       // second half of the word in flight
  logic              overflow_q, overflow_d;

  assign flush     = ~reset_n | ~user_w_spi_cmd_32_open;
  assign fifo_push = user_w_spi_cmd_32_wren & ~fifo_full & user_w_spi_cmd_32_open;
  assign handshake = valid_q & cmd_ready;

  spi_cmd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (HOST_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (bus_clk),
    .flush (flush),
    .push  (fifo_push),
    .wdata (user_w_spi_cmd_32_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (cmd_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    hi_d     = hi_q;
    fifo_pop = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      data_d  = '0;
      valid_d = 1'b0;
      hi_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = lo_half(fifo_rdata);
            hi_d     = hi_half(fifo_rdata);
            valid_d  = 1'b1;
            state_d  = ST_LOW;
          end
        end
        ST_LOW: begin
          if (handshake) begin
            data_d  = hi_q;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          // Chain straight into the next word so there is no bubble.
          if (handshake) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              data_d   = lo_half(fifo_rdata);
              hi_d     = hi_half(fifo_rdata);
              state_d  = ST_LOW;
            end else begin
              valid_d = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Writes while closed are not overflows; flush wins over a set.
  assign overflow_d = flush ? 1'b0
                    : (overflow_q | (user_w_spi_cmd_32_wren & fifo_full));

  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      hi_q       <= hi_d;
      overflow_q <= overflow_d;
    end
  end

  assign user_w_spi_cmd_32_full = fifo_full;
  assign cmd_data               = data_q;
  assign cmd_valid              = valid_q;
  assign cmd_overflow           = overflow_q;

`ifdef SPI_CMD_WORD_CNT_EN
  logic [31:0] count_q, count_d;

  // Wraps naturally at 2^32.
  assign count_d = flush ? 32'd0 : (count_q + (handshake ? 32'd1 : 32'd0));

  always_ff @(posedge bus_clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign cmd_count = count_q;
`endif

endmodule
